// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage owning the program counter.
//   Issues word requests to instruction memory, tracks in-flight requests,
//   and buffers in-order responses in a small queue for decode. A branch
//   redirect flushes wrong-path state and restarts fetch at the target.
// Optional feature (macro FETCH_PERF_EN): saturating performance counters
//   perf_fetched / perf_redirects / perf_dropped.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   branch_taken        redirect strobe; target_address is the new PC
//   halt                one-cycle stop-fetch strobe from decode
//   imem_req/addr/gnt   request channel to instruction memory
//   imem_rvalid/rdata   in-order response channel (never back-pressured)
//   if_valid/instr/pc   queue head presented to decode
//   id_ready            decode accepts the head this cycle
module fetch_unit #(
  parameter int unsigned     PC_W     = 19,
  parameter int unsigned     INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     Q_DEPTH  = 4,
  parameter int unsigned     MAX_OUT  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    target_address,
  input  logic               halt,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  input  logic               id_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [15:0]        perf_redirects,
  output logic [15:0]        perf_dropped
`endif
);

  localparam int unsigned QP_W  = $clog2(Q_DEPTH);
  localparam int unsigned CNT_W = $clog2(Q_DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
  localparam int unsigned FP_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic [OUT_W-1:0]   drop_q, drop_d;
  logic [INSTR_W-1:0] q_instr_q [Q_DEPTH];
  logic [PC_W-1:0]    q_pc_q    [Q_DEPTH];
  logic [QP_W-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PC_W-1:0]    pf_mem_q  [MAX_OUT];
  logic [FP_W-1:0]    pf_rd_q, pf_rd_d, pf_wr_q, pf_wr_d;

  logic hs, pop, push, pf_push;

  // Non-power-of-two wrap for the request-side PC FIFO.
  function automatic logic [FP_W-1:0] pf_inc(input logic [FP_W-1:0] p);
    return (32'(p) == MAX_OUT - 1) ? '0 : p + 1'b1;
  endfunction

  // Request only when every possible response is guaranteed a queue slot.
  assign imem_req  = (state_q == S_RUN) && (32'(out_q) < MAX_OUT) &&
                     ((32'(count_q) + 32'(out_q)) < Q_DEPTH);
  assign imem_addr = pc_q;
  assign if_valid  = (count_q != '0);
  assign if_instr  = q_instr_q[rd_q];
  assign if_pc     = q_pc_q[rd_q];

  assign hs  = imem_req & imem_gnt;
  assign pop = if_valid & id_ready;

  // Next-state logic: FSM, PC, outstanding/drop accounting, queue pointers.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    out_d   = out_q + OUT_W'(hs) - OUT_W'(imem_rvalid);
    drop_d  = drop_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    pf_rd_d = pf_rd_q;
    pf_wr_d = pf_wr_q;
    push    = 1'b0;
    pf_push = 1'b0;

    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (halt) state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase

    if (branch_taken) begin
      // Everything still pending after this cycle belongs to the old path.
      state_d = S_RUN;
      pc_d    = target_address;
      drop_d  = out_d;
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
      pf_rd_d = '0;
      pf_wr_d = '0;
    end else begin
      if (hs) begin
        pc_d    = pc_q + 1'b1;
        pf_push = 1'b1;
        pf_wr_d = pf_inc(pf_wr_q);
      end
      if (imem_rvalid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - 1'b1;
        end else begin
          push    = 1'b1;
          wr_d    = wr_q + 1'b1;
          pf_rd_d = pf_inc(pf_rd_q);
        end
      end
      if (pop) rd_d = rd_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State and storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_PC;
      out_q     <= '0;
      drop_q    <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      count_q   <= '0;
      pf_rd_q   <= '0;
      pf_wr_q   <= '0;
      q_instr_q <= '{default: '0};
      q_pc_q    <= '{default: RESET_PC};
      pf_mem_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      pf_rd_q <= pf_rd_d;
      pf_wr_q <= pf_wr_d;
      if (push) begin
        q_instr_q[wr_q] <= imem_rdata;
        q_pc_q[wr_q]    <= pf_mem_q[pf_rd_q];
      end
      if (pf_push) pf_mem_q[pf_wr_q] <= pc_q;
    end
  end

`ifdef FETCH_PERF_EN
  logic rsp_drop;
  // A response in the redirect cycle is discarded as well.
  assign rsp_drop = imem_rvalid & (branch_taken | (drop_q != '0));

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched   <= '0;
      perf_redirects <= '0;
      perf_dropped   <= '0;
    end else begin
      if (pop && (perf_fetched != '1))            perf_fetched   <= perf_fetched + 1'b1;
      if (branch_taken && (perf_redirects != '1)) perf_redirects <= perf_redirects + 1'b1;
      if (rsp_drop && (perf_dropped != '1))       perf_dropped   <= perf_dropped + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with an in-order imem model.
module tb_fetch_unit;
  localparam int unsigned PC_W    = 19;
  localparam int unsigned INSTR_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, branch_taken, halt, imem_gnt, id_ready;
  logic [PC_W-1:0]    target_address;
  logic               imem_req, if_valid;
  logic [PC_W-1:0]    imem_addr, if_pc;
  logic               imem_rvalid = 1'b0;
  logic [INSTR_W-1:0] imem_rdata  = '0;
  logic [INSTR_W-1:0] if_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [15:0] perf_redirects, perf_dropped;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit u_dut (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .target_address(target_address),
    .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_redirects(perf_redirects), .perf_dropped(perf_dropped)
`endif
  );

  // In-order memory with programmable latency; data = 0xC0000000 | address.
  typedef struct packed { logic [PC_W-1:0] addr; int unsigned due; } rsp_t;
  rsp_t        pend[$];
  int unsigned cyc = 0;
  int unsigned lat = 1;

  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
    end else begin
      if (imem_rvalid && pend.size() > 0) void'(pend.pop_front());
      if (imem_req && imem_gnt) pend.push_back('{addr: imem_addr, due: cyc + lat});
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hC000_0000 | 32'(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  end

  // Second instance exercising PC wrap from a high reset vector.
  logic               w_req, w_valid;
  logic [PC_W-1:0]    w_addr, w_pc;
  logic [INSTR_W-1:0] w_instr;
  logic               w_rvalid = 1'b0;
  logic [INSTR_W-1:0] w_rdata  = '0;
  logic               w_hs_q   = 1'b0;
  logic [PC_W-1:0]    w_addr_q = '0;
  logic [PC_W-1:0]    w_pcs [4];
  int                 w_n = 0;
`ifdef FETCH_PERF_EN
  logic [31:0] w_pf;
  logic [15:0] w_pr, w_pd;
`endif

  fetch_unit #(.RESET_PC(19'h7FFFE)) u_wrap (
    .clk(clk), .rst(rst), .branch_taken(1'b0), .target_address('0),
    .halt(1'b0), .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata), .if_valid(w_valid),
    .if_instr(w_instr), .if_pc(w_pc), .id_ready(1'b1)
`ifdef FETCH_PERF_EN
    , .perf_fetched(w_pf), .perf_redirects(w_pr), .perf_dropped(w_pd)
`endif
  );

  always @(posedge clk) begin
    w_hs_q   = !rst && w_req;
    w_addr_q = w_addr;
  end

  always @(negedge clk) begin
    w_rvalid = w_hs_q;
    w_rdata  = 32'hC000_0000 | 32'(w_addr_q);
    if (w_valid && w_n < 4) begin
      w_pcs[w_n] = w_pc;
      w_n++;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!if_valid && n < 30) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 32'(if_valid), 32'd1);
  endtask

  initial begin
    logic [PC_W-1:0] exp_w [4];
    exp_w = '{19'h7FFFE, 19'h7FFFF, 19'h00000, 19'h00001};

    rst = 1'b1; branch_taken = 1'b0; halt = 1'b0; target_address = '0;
    imem_gnt = 1'b1; id_ready = 1'b1; lat = 1;
    step(); step();

    // Reset values
    check("rst_req",   32'(imem_req),  32'd0);
    check("rst_valid", 32'(if_valid),  32'd0);
    check("rst_addr",  32'(imem_addr), 32'd0);
    check("rst_pc",    32'(if_pc),     32'd0);
    check("rst_instr", if_instr,       32'd0);
    rst = 1'b0;

    // BOOT cycle, then streaming
    step();
    check("boot_req",  32'(imem_req),  32'd1);
    check("boot_addr", 32'(imem_addr), 32'd0);
    step();
    check("fill_valid", 32'(if_valid), 32'd0);
    step();
    for (int i = 0; i < 6; i++) begin
      check("stream_valid", 32'(if_valid), 32'd1);
      check("stream_pc",    32'(if_pc),    32'(i));
      check("stream_instr", if_instr,      32'hC000_0000 | 32'(i));
      step();
    end

    // Backpressure: queue fills to 4, requests stop
    id_ready = 1'b0;
    repeat (10) step();
    check("bp_req",   32'(imem_req),        32'd0);
    check("bp_count", 32'(u_dut.count_q),   32'd4);
    check("bp_pc",    32'(if_pc),           32'd6);
    id_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("bp_rel_valid", 32'(if_valid), 32'd1);
      check("bp_rel_pc",    32'(if_pc),    32'(6 + i));
      step();
    end

    // Redirect with two outstanding requests, 3-cycle latency
    lat = 3; imem_gnt = 1'b0;
    repeat (8) step();
    check("quiet_valid", 32'(if_valid), 32'd0);
    imem_gnt = 1'b1;
    step(); step();
    check("two_out_req", 32'(imem_req), 32'd0);
    branch_taken = 1'b1; target_address = 19'h00100;
    step();
    branch_taken = 1'b0;
    check("redir_valid0", 32'(if_valid),  32'd0);
    check("redir_addr",   32'(imem_addr), 32'h100);
    wait_valid("redir");
    check("redir_pc",    32'(if_pc), 32'h100);
    check("redir_instr", if_instr,   32'hC000_0100);

    // Halt: requests stop while the queue drains
    lat = 1;
    repeat (5) step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("halt_req", 32'(imem_req), 32'd0);
      step();
    end
    check("halt_drained", 32'(if_valid), 32'd0);
    branch_taken = 1'b1; target_address = 19'h00040;
    step();
    branch_taken = 1'b0;
    check("resume_req",  32'(imem_req),  32'd1);
    check("resume_addr", 32'(imem_addr), 32'h40);
    wait_valid("resume");
    check("resume_pc", 32'(if_pc), 32'h40);
    step(); step();

    // Halt and redirect together: redirect wins, fetch keeps running
    halt = 1'b1; branch_taken = 1'b1; target_address = 19'h00200;
    step();
    halt = 1'b0; branch_taken = 1'b0;
    check("combo_req",    32'(imem_req),  32'd1);
    check("combo_addr",   32'(imem_addr), 32'h200);
    check("combo_valid0", 32'(if_valid),  32'd0);
    step();
    check("combo_req2", 32'(imem_req), 32'd1);
    wait_valid("combo");
    check("combo_pc", 32'(if_pc), 32'h200);
`ifdef FETCH_PERF_EN
    check("perf_redirects", 32'(perf_redirects), 32'd3);
    check("perf_dropped",   32'(perf_dropped),   32'd4);
`endif

    // Reset with two requests in flight
    lat = 3; imem_gnt = 1'b0;
    repeat (8) step();
    imem_gnt = 1'b1;
    step(); step();
    check("mid_two_out", 32'(imem_req), 32'd0);
    rst = 1'b1;
    step();
    check("mid_rst_req",   32'(imem_req),  32'd0);
    check("mid_rst_valid", 32'(if_valid),  32'd0);
    check("mid_rst_addr",  32'(imem_addr), 32'd0);
    check("mid_rst_pc",    32'(if_pc),     32'd0);
    check("mid_rst_instr", if_instr,       32'd0);
`ifdef FETCH_PERF_EN
    check("mid_rst_pf", perf_fetched,         32'd0);
    check("mid_rst_pr", 32'(perf_redirects),  32'd0);
    check("mid_rst_pd", 32'(perf_dropped),    32'd0);
`endif
    rst = 1'b0; lat = 1;
    step();
    check("mid_boot_req",  32'(imem_req),  32'd1);
    check("mid_boot_addr", 32'(imem_addr), 32'd0);
    wait_valid("mid_restart");
    check("mid_restart_pc",    32'(if_pc), 32'd0);
    check("mid_restart_instr", if_instr,   32'hC000_0000);

    // PC wrap on the second instance
    check("wrap_count", 32'(w_n), 32'd4);
    for (int i = 0; i < 4; i++) check("wrap_pc", 32'(w_pcs[i]), 32'(exp_w[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
